// File: rtl/tl_ul_pkg.sv
// Shared TL-UL definitions: opcodes, field widths and packed A/D field groups.
// A/D beats are laid out MSB-first as {header, source, payload}. The source
// width varies per port, so it sits between two fixed-width structs.
package tl_ul_pkg;

    localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_A_GET             = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    localparam int TL_ADDR_W = 32;
    localparam int TL_DATA_W = 32;
    localparam int TL_MASK_W = TL_DATA_W / 8;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] param;
        logic [2:0] size;
    } tl_a_hdr_t;

    typedef struct packed {
        logic [TL_ADDR_W-1:0] address;
        logic [TL_MASK_W-1:0] mask;
        logic [TL_DATA_W-1:0] data;
        logic                 corrupt;
    } tl_a_pay_t;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] param;
        logic [2:0] size;
    } tl_d_hdr_t;

    typedef struct packed {
        logic                 denied;
        logic [TL_DATA_W-1:0] data;
        logic                 corrupt;
    } tl_d_pay_t;

    localparam int TL_A_HDR_W = $bits(tl_a_hdr_t);
    localparam int TL_A_PAY_W = $bits(tl_a_pay_t);
    localparam int TL_D_HDR_W = $bits(tl_d_hdr_t);
    localparam int TL_D_PAY_W = $bits(tl_d_pay_t);

    // Total A beat width for a given source width.
    function automatic int tl_a_bits_w(input int src_w);
        return TL_A_HDR_W + src_w + TL_A_PAY_W;
    endfunction

    // Total D beat width for a given source width.
    function automatic int tl_d_bits_w(input int src_w);
        return TL_D_HDR_W + src_w + TL_D_PAY_W;
    endfunction

endpackage

// File: rtl/tl_arb_credit_ctr.sv
// Outstanding-request counter for one master, range 0..MAX_OUT.
// An increment and a decrement in the same cycle cancel out. A decrement at zero
// leaves the count at zero and raises underflow for that cycle.
module tl_arb_credit_ctr
#(
    parameter int MAX_OUT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic underflow
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Count granted requests up and completed responses down, saturating at both ends.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (inc && !dec && !full) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign full      = (cnt_q == CNT_W'(MAX_OUT));
    assign underflow = dec && !inc && (cnt_q == '0);

endmodule

// File: rtl/tl_ul_arb2.sv
// 2:1 TL-UL A-channel arbiter with D-channel response routing.
// The outbound source is {master index, master source}. Responses are routed back
// by the source MSB, which is then stripped. Each master has at most MAX_OUT
// requests in flight. A stalled grant is held until it is accepted.
// Build option: define TL_ARB2_RR_EN for round-robin between eligible masters.
// Otherwise m0 has fixed priority.
module tl_ul_arb2
    import tl_ul_pkg::*;
#(
    parameter int SRC_W   = 2,
    parameter int MAX_OUT = 4
) (
    input  logic                              clock,
    input  logic                              reset_n,

    input  logic                              m0_a_valid,
    output logic                              m0_a_ready,
    input  logic [tl_a_bits_w(SRC_W)-1:0]     m0_a_bits,
    output logic                              m0_d_valid,
    input  logic                              m0_d_ready,
    output logic [tl_d_bits_w(SRC_W)-1:0]     m0_d_bits,

    input  logic                              m1_a_valid,
    output logic                              m1_a_ready,
    input  logic [tl_a_bits_w(SRC_W)-1:0]     m1_a_bits,
    output logic                              m1_d_valid,
    input  logic                              m1_d_ready,
    output logic [tl_d_bits_w(SRC_W)-1:0]     m1_d_bits,

    output logic                              s_a_valid,
    input  logic                              s_a_ready,
    output logic [tl_a_bits_w(SRC_W+1)-1:0]   s_a_bits,
    input  logic                              s_d_valid,
    output logic                              s_d_ready,
    input  logic [tl_d_bits_w(SRC_W+1)-1:0]   s_d_bits
);

    localparam int MA_W = tl_a_bits_w(SRC_W);

    logic             full0, full1;
    logic             uf0, uf1;
    logic             elig0, elig1;
    logic             lock_q, lock_idx_q;
    logic             win;
    logic             a_fire, d_fire;
    logic             d_idx;
    logic [MA_W-1:0]  win_bits;
    tl_a_hdr_t        a_hdr;
    logic [SRC_W-1:0] a_src;
    tl_a_pay_t        a_pay;
    tl_d_hdr_t        d_hdr;
    logic [SRC_W-1:0] d_src;
    tl_d_pay_t        d_pay;

    // A master at its credit limit cannot compete.
    assign elig0 = m0_a_valid && !full0;
    assign elig1 = m1_a_valid && !full1;

`ifdef TL_ARB2_RR_EN
    logic rr_q;

    // Round-robin pointer: after each accepted request, prefer the other master.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= 1'b0;
        end else if (a_fire) begin
            rr_q <= ~win;
        end
    end
`endif

    // Winner selection: a held grant overrides fresh arbitration. s_a_ready is not used here.
    always_comb begin
        win       = 1'b0;
        s_a_valid = 1'b0;
        if (lock_q) begin
            win       = lock_idx_q;
            s_a_valid = lock_idx_q ? m1_a_valid : m0_a_valid;
        end else begin
            s_a_valid = elig0 || elig1;
`ifdef TL_ARB2_RR_EN
            if (elig0 && elig1) begin
                win = rr_q;
            end else begin
                win = !elig0;
            end
`else
            win = !elig0;
`endif
        end
    end

    // Hold the grant while the slave stalls so the offered beat stays stable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_q     <= 1'b0;
            lock_idx_q <= 1'b0;
        end else if (a_fire) begin
            lock_q     <= 1'b0;
        end else if (s_a_valid) begin
            lock_q     <= 1'b1;
            lock_idx_q <= win;
        end
    end

    assign win_bits                = win ? m1_a_bits : m0_a_bits;
    assign {a_hdr, a_src, a_pay}   = win_bits;
    assign s_a_bits                = {a_hdr, win, a_src, a_pay};
    assign a_fire                  = s_a_valid && s_a_ready;
    assign m0_a_ready              = s_a_ready && s_a_valid && !win;
    assign m1_a_ready              = s_a_ready && s_a_valid &&  win;

    // The response path has no storage: the source MSB steers valid and ready.
    assign {d_hdr, d_idx, d_src, d_pay} = s_d_bits;
    assign m0_d_bits  = {d_hdr, d_src, d_pay};
    assign m1_d_bits  = {d_hdr, d_src, d_pay};
    assign m0_d_valid = reset_n && s_d_valid && !d_idx;
    assign m1_d_valid = reset_n && s_d_valid &&  d_idx;
    assign s_d_ready  = reset_n && (d_idx ? m1_d_ready : m0_d_ready);
    assign d_fire     = s_d_valid && s_d_ready;

    tl_arb_credit_ctr #(
        .MAX_OUT   (MAX_OUT)
    ) u_ctr0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .inc       (a_fire && !win),
        .dec       (d_fire && !d_idx),
        .full      (full0),
        .underflow (uf0)
    );

    tl_arb_credit_ctr #(
        .MAX_OUT   (MAX_OUT)
    ) u_ctr1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .inc       (a_fire &&  win),
        .dec       (d_fire &&  d_idx),
        .full      (full1),
        .underflow (uf1)
    );

`ifndef SYNTHESIS
    // A response for a master with nothing outstanding means the slave is broken.
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n) !(uf0 || uf1));
`endif

endmodule

// File: tb/tb_tl_ul_arb2.sv
// Self-checking bench for tl_ul_arb2.
// Accepted A beats and D beats are checked against queues of expected beats.
module tb_tl_ul_arb2;

    localparam int SRC_W = 2;
    localparam int MA_W  = 78 + SRC_W;
    localparam int SA_W  = MA_W + 1;
    localparam int MD_W  = 42 + SRC_W;
    localparam int SD_W  = MD_W + 1;

    localparam logic [2:0] OP_PUTF = 3'd0;
    localparam logic [2:0] OP_GET  = 3'd4;
    localparam logic [2:0] OP_ACK  = 3'd0;
    localparam logic [2:0] OP_ACKD = 3'd1;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            m0_a_valid, m0_a_ready, m0_d_valid, m0_d_ready;
    logic            m1_a_valid, m1_a_ready, m1_d_valid, m1_d_ready;
    logic [MA_W-1:0] m0_a_bits, m1_a_bits;
    logic [MD_W-1:0] m0_d_bits, m1_d_bits;
    logic            s_a_valid, s_a_ready, s_d_valid, s_d_ready;
    logic [SA_W-1:0] s_a_bits;
    logic [SD_W-1:0] s_d_bits;

    int n_chk = 0;
    int n_err = 0;
    logic [SA_W-1:0] exp_a[$];
    logic [MD_W:0]   exp_d[$];

    always #5 clock = ~clock;

    tl_ul_arb2 #(.SRC_W(SRC_W), .MAX_OUT(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .m0_a_valid (m0_a_valid),
        .m0_a_ready (m0_a_ready),
        .m0_a_bits  (m0_a_bits),
        .m0_d_valid (m0_d_valid),
        .m0_d_ready (m0_d_ready),
        .m0_d_bits  (m0_d_bits),
        .m1_a_valid (m1_a_valid),
        .m1_a_ready (m1_a_ready),
        .m1_a_bits  (m1_a_bits),
        .m1_d_valid (m1_d_valid),
        .m1_d_ready (m1_d_ready),
        .m1_d_bits  (m1_d_bits),
        .s_a_valid  (s_a_valid),
        .s_a_ready  (s_a_ready),
        .s_a_bits   (s_a_bits),
        .s_d_valid  (s_d_valid),
        .s_d_ready  (s_d_ready),
        .s_d_bits   (s_d_bits)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [MA_W-1:0] mk_a(input logic [2:0] op, input logic [1:0] src,
                                             input logic [31:0] addr, input logic [31:0] data);
        return {op, 3'd0, 3'd2, src, addr, 4'hF, data, 1'b0};
    endfunction

    function automatic logic [SA_W-1:0] sa(input logic idx, input logic [MA_W-1:0] a);
        return {a[MA_W-1:71], idx, a[70:0]};
    endfunction

    function automatic logic [SD_W-1:0] mk_sd(input logic [2:0] src, input logic [2:0] op,
                                              input logic [31:0] data);
        return {op, 2'd0, 3'd2, src, 1'b0, data, 1'b0};
    endfunction

    function automatic logic [MD_W-1:0] mk_md(input logic [1:0] src, input logic [2:0] op,
                                              input logic [31:0] data);
        return {op, 2'd0, 3'd2, src, 1'b0, data, 1'b0};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        m0_a_valid = 1'b0;
        m1_a_valid = 1'b0;
        s_d_valid  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Scoreboard: every accepted beat must match the oldest expected one.
    always @(negedge clock) begin
        if (s_a_valid && s_a_ready) begin
            if (exp_a.size() == 0) check("a_unexpected", 1'b1, 1'b0);
            else                   check("a_beat", s_a_bits, exp_a.pop_front());
        end
        if (m0_d_valid && m0_d_ready) begin
            if (exp_d.size() == 0) check("d0_unexpected", 1'b1, 1'b0);
            else                   check("d0_beat", {1'b0, m0_d_bits}, exp_d.pop_front());
        end
        if (m1_d_valid && m1_d_ready) begin
            if (exp_d.size() == 0) check("d1_unexpected", 1'b1, 1'b0);
            else                   check("d1_beat", {1'b1, m1_d_bits}, exp_d.pop_front());
        end
    end

    initial begin
        logic w;
        reset_n    = 1'b0;
        m0_a_valid = 1'b0; m0_a_bits = '0; m0_d_ready = 1'b1;
        m1_a_valid = 1'b0; m1_a_bits = '0; m1_d_ready = 1'b1;
        s_a_ready  = 1'b1;
        s_d_valid  = 1'b1; s_d_bits = mk_sd(3'b001, OP_ACK, 32'h0);

        // Test 1: under reset a D beat is blocked; after release everything is idle.
        @(negedge clock);
        check("rst_m0_dvalid", m0_d_valid, 1'b0);
        check("rst_s_dready", s_d_ready, 1'b0);
        s_d_valid = 1'b0;
        do_reset();
        cyc();
        @(negedge clock);
        check("t1_s_avalid", s_a_valid, 1'b0);
        check("t1_d_valid", {m0_d_valid, m1_d_valid}, 2'b00);
        check("t1_a_ready", {m0_a_ready, m1_a_ready}, 2'b00);

        // Test 2: a single m0 Get is tagged with index 0.
        cyc();
        m0_a_valid = 1'b1;
        m0_a_bits  = mk_a(OP_GET, 2'd1, 32'h1000, 32'h0);
        exp_a.push_back(sa(1'b0, m0_a_bits));
        @(negedge clock);
        check("t2_s_avalid", s_a_valid, 1'b1);
        check("t2_a_ready", {m0_a_ready, m1_a_ready}, 2'b10);
        check("t2_source", s_a_bits[71:69], 3'b001);
        cyc();
        m0_a_valid = 1'b0;
        @(negedge clock);
        check("t2_idle", s_a_valid, 1'b0);
        cyc();
        s_d_valid = 1'b1;
        s_d_bits  = mk_sd(3'b001, OP_ACKD, 32'h1234_5678);
        exp_d.push_back({1'b0, mk_md(2'd1, OP_ACKD, 32'h1234_5678)});
        @(negedge clock);
        check("t2_d_valid", {m0_d_valid, m1_d_valid}, 2'b10);
        check("t2_s_dready", s_d_ready, 1'b1);
        cyc();
        s_d_valid = 1'b0;

        // Test 3: both masters request for four cycles.
        do_reset();
        cyc();
        m0_a_valid = 1'b1; m0_a_bits = mk_a(OP_GET, 2'd0, 32'h2000, 32'h0);
        m1_a_valid = 1'b1; m1_a_bits = mk_a(OP_GET, 2'd2, 32'h3000, 32'h0);
        for (int i = 0; i < 4; i++) begin
`ifdef TL_ARB2_RR_EN
            w = i[0];
`else
            w = 1'b0;
`endif
            exp_a.push_back(sa(w, w ? m1_a_bits : m0_a_bits));
            @(negedge clock);
            check("t3_grant", {m0_a_ready, m1_a_ready}, {!w, w});
            cyc();
        end
        m0_a_valid = 1'b0;
        m1_a_valid = 1'b0;

        // Test 4: the stalled m1 grant is held while m0 joins.
        do_reset();
        cyc();
        s_a_ready  = 1'b0;
        m1_a_valid = 1'b1;
        m1_a_bits  = mk_a(OP_PUTF, 2'd3, 32'h4000, 32'hCAFE_0001);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                m0_a_valid = 1'b1;
                m0_a_bits  = mk_a(OP_GET, 2'd0, 32'h5000, 32'h0);
            end
            @(negedge clock);
            check("t4_hold_valid", s_a_valid, 1'b1);
            check("t4_hold_bits", s_a_bits, sa(1'b1, m1_a_bits));
            check("t4_hold_ready", {m0_a_ready, m1_a_ready}, 2'b00);
            cyc();
        end
        s_a_ready = 1'b1;
        exp_a.push_back(sa(1'b1, m1_a_bits));
        @(negedge clock);
        check("t4_m1_fire", {m0_a_ready, m1_a_ready}, 2'b01);
        cyc();
        m1_a_valid = 1'b0;
        exp_a.push_back(sa(1'b0, m0_a_bits));
        @(negedge clock);
        check("t4_m0_fire", {m0_a_ready, m1_a_ready}, 2'b10);
        cyc();
        m0_a_valid = 1'b0;

        // Test 5: the fifth m0 Get waits for a credit.
        do_reset();
        cyc();
        for (int i = 0; i < 4; i++) begin
            m0_a_valid = 1'b1;
            m0_a_bits  = mk_a(OP_GET, 2'd0, 32'h6000 + 32'(i * 4), 32'h0);
            exp_a.push_back(sa(1'b0, m0_a_bits));
            @(negedge clock);
            check("t5_issue", m0_a_ready, 1'b1);
            cyc();
        end
        m0_a_bits = mk_a(OP_GET, 2'd0, 32'h6010, 32'h0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clock);
            check("t5_full_ready", m0_a_ready, 1'b0);
            check("t5_full_valid", s_a_valid, 1'b0);
            cyc();
        end
        s_d_valid = 1'b1;
        s_d_bits  = mk_sd(3'b000, OP_ACK, 32'h0);
        exp_d.push_back({1'b0, mk_md(2'd0, OP_ACK, 32'h0)});
        @(negedge clock);
        check("t5_d_valid", m0_d_valid, 1'b1);
        check("t5_still_full", m0_a_ready, 1'b0);
        cyc();
        s_d_valid = 1'b0;
        exp_a.push_back(sa(1'b0, m0_a_bits));
        @(negedge clock);
        check("t5_resume", m0_a_ready, 1'b1);
        cyc();
        m0_a_valid = 1'b0;

        // Test 6: an m1 response stalls; the credit returns only on the handshake.
        do_reset();
        cyc();
        for (int i = 0; i < 4; i++) begin
            m1_a_valid = 1'b1;
            m1_a_bits  = mk_a(OP_GET, 2'd2, 32'h7000 + 32'(i * 4), 32'h0);
            exp_a.push_back(sa(1'b1, m1_a_bits));
            @(negedge clock);
            check("t6_issue", m1_a_ready, 1'b1);
            cyc();
        end
        m1_a_bits  = mk_a(OP_GET, 2'd2, 32'h7010, 32'h0);
        s_d_valid  = 1'b1;
        s_d_bits   = mk_sd(3'b110, OP_ACKD, 32'hDEAD_BEEF);
        m1_d_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clock);
            check("t6_d_valid", {m0_d_valid, m1_d_valid}, 2'b01);
            check("t6_s_dready", s_d_ready, 1'b0);
            check("t6_d_bits", m1_d_bits, mk_md(2'b10, OP_ACKD, 32'hDEAD_BEEF));
            check("t6_full_ready", m1_a_ready, 1'b0);
            cyc();
        end
        m1_d_ready = 1'b1;
        exp_d.push_back({1'b1, mk_md(2'b10, OP_ACKD, 32'hDEAD_BEEF)});
        @(negedge clock);
        check("t6_d_fire", {m0_d_valid, m1_d_valid, s_d_ready}, 3'b011);
        check("t6_fire_ready", m1_a_ready, 1'b0);
        cyc();
        s_d_valid = 1'b0;
        exp_a.push_back(sa(1'b1, m1_a_bits));
        @(negedge clock);
        check("t6_resume", m1_a_ready, 1'b1);
        cyc();
        m1_a_valid = 1'b0;

        // Test 7: a request and a response for m0 in the same cycle leave the count unchanged.
        do_reset();
        cyc();
        for (int i = 0; i < 3; i++) begin
            m0_a_valid = 1'b1;
            m0_a_bits  = mk_a(OP_GET, 2'd1, 32'h8000 + 32'(i * 4), 32'h0);
            exp_a.push_back(sa(1'b0, m0_a_bits));
            @(negedge clock);
            check("t7_issue", m0_a_ready, 1'b1);
            cyc();
        end
        m0_a_bits = mk_a(OP_GET, 2'd1, 32'h8100, 32'h0);
        exp_a.push_back(sa(1'b0, m0_a_bits));
        s_d_valid = 1'b1;
        s_d_bits  = mk_sd(3'b001, OP_ACK, 32'h0);
        exp_d.push_back({1'b0, mk_md(2'd1, OP_ACK, 32'h0)});
        @(negedge clock);
        check("t7_both_fire", {m0_a_ready, m0_d_valid, s_d_ready}, 3'b111);
        cyc();
        s_d_valid = 1'b0;
        m0_a_bits = mk_a(OP_GET, 2'd1, 32'h8104, 32'h0);
        exp_a.push_back(sa(1'b0, m0_a_bits));
        @(negedge clock);
        check("t7_last_credit", m0_a_ready, 1'b1);
        cyc();
        m0_a_bits = mk_a(OP_GET, 2'd1, 32'h8108, 32'h0);
        @(negedge clock);
        check("t7_full", m0_a_ready, 1'b0);
        cyc();
        m0_a_valid = 1'b0;

        @(negedge clock);
        check("a_queue_empty", 32'(exp_a.size()), 32'd0);
        check("d_queue_empty", 32'(exp_d.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
